issue_sched: RTL and testbench
==============================

# issue_sched

Issue scheduler for the reservation station: each cycle it picks at most one ready entry per functional unit (ALU0, ALU1, MEM) and issues a registered grant to the station. It owns the functional-unit availability table, so the station no longer computes FU readiness itself. It sits between the reservation-station ready vector and the three FU issue ports. ALU occupancy is timed internally; MEM occupancy is released by a completion pulse.

## Interface
- `NUM_REQ`, 8: number of reservation-station entries presented as candidates.
- `IDXW`, 3: index width, equal to clog2(`NUM_REQ`).
- `ALU_LAT`, 1: cycles an ALU stays busy after a grant; range 1..15.
- `clk`, input, 1: clock, rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, `NUM_REQ`: entry i is in use and both operands are ready.
- `req_fu`, input, 2*`NUM_REQ`: FU id for entry i in bits [2i+1:2i]. 00 = ALU0, 01 = ALU1, 10 = MEM, 11 = none (never granted).
- `mem_done`, input, 1: single-cycle pulse; the MEM unit has finished its op.
- `flush`, input, 1: discard pending grants and ALU occupancy.
- `grant_valid`, output, 3: bit f set means FU f received an issue this cycle.
- `grant_idx`, output, 3*`IDXW`: the granted entry index for FU f, in bits [f*IDXW +: IDXW].
- `fu_free`, output, 3: FU availability table, 1 = free. Same polarity as the existing FU table.

## Operation
- Candidate set for FU f: entries with `req_valid`=1 and `req_fu`=f, minus the masked entry (see next bullet). Candidates are considered only when `fu_free[f]`=1 and `flush`=0.
- Double-issue mask: an entry granted in the previous cycle (any `grant_valid` bit set with that index) is excluded. This is needed because the station clears its entry one edge after the grant.
- Arbitration is round-robin per FU.
  - Each FU keeps a pointer `rr[f]`.
  - The search starts at `rr[f]` and wraps past `NUM_REQ`-1 back to 0.
  - On a grant, `rr[f]` becomes the granted index + 1, modulo `NUM_REQ`.
  - Without a grant, `rr[f]` holds.
- One entry has exactly one FU id, so no entry can be granted to two FUs in the same cycle.
- ALU occupancy: each ALU has a 4-bit down-counter.
  - A grant loads the counter with `ALU_LAT`.
  - The counter decrements every cycle while nonzero.
  - `fu_free[f]` = (counter == 0).
- MEM occupancy: a busy flag.
  - Set by a MEM grant.
  - Cleared by `mem_done`.
  - A `mem_done` arriving while MEM is already free is ignored.
  - If `mem_done` and a MEM grant fall on the same edge, the grant wins. This cannot occur legally, because grants require `fu_free[2]`=1.
- Flush:
  - Clears `grant_valid`.
  - Zeroes both ALU counters.
  - Clears the double-issue mask.
  - Keeps the MEM busy flag, because the memory op is still in flight and must complete with `mem_done`.
  - Keeps the `rr` pointers.
- FU id 11 entries are never granted and never move any pointer.

## Timing
- Reset values:
  - `grant_valid`=000
  - `grant_idx`=0
  - `fu_free`=111
  - ALU counters 0, MEM flag 0, `rr` pointers 0, mask empty.
  - Reset mid-operation abandons any in-flight MEM op.
- All outputs are registered.
- Request to grant: `req_valid` sampled at edge E produces the grant visible after E. The station consumes it at E+1.
- `fu_free[f]` drops on the same edge that asserts `grant_valid[f]`.
- ALU turnaround: an ALU granted at edge E is free again after edge E+`ALU_LAT`. The next grant to that ALU comes at E+`ALU_LAT` at the earliest, to a different entry if the same one is still masked.
- MEM turnaround: `mem_done` at edge D sets `fu_free[2]`=1 after D. The next MEM grant comes at edge D+1 at the earliest. There is no combinational bypass.
- `grant_valid` is a one-cycle pulse per grant. Back-to-back pulses occur only for ALUs with `ALU_LAT`=1.

## Configuration
- `ISSUE_FIXED_PRIO_EN` defined: fixed priority, where the lowest candidate index wins. The `rr` pointers are not built and grant order ignores history.
- `ISSUE_FIXED_PRIO_EN` undefined (default): round-robin as specified above.
- Masking, occupancy and flush behave identically in both builds.

## Test plan
- Reset, then all requests low: `fu_free`=111 and `grant_valid`=000 for 10 cycles.
- Single entry issue: entries 2 and 5 both request ALU0, `ALU_LAT`=1, requests held.
  - Grants alternate 2, 5, 2, 5 on successive cycles.
  - Entry 2 is never granted two cycles in a row.
  - With `ISSUE_FIXED_PRIO_EN`, the order is 2, 5, 2, 5, due to the mask.
- Round-robin wrap: entries 0, 6 and 7 request ALU1 with `rr`=6. The grant order is 6, 7, 0, 6.
- MEM occupancy:
  - Entries 1 and 3 request MEM; entry 1 is granted and `fu_free[2]`=0.
  - Hold for 5 cycles with no MEM grant.
  - Pulse `mem_done`: `fu_free[2]`=1 the next cycle, and entry 3 is granted one cycle later.
- Flush:
  - Set `ALU_LAT`=4 and grant ALU0.
  - At cycle 2 assert `flush` with MEM busy.
  - Required result: ALU0 free next cycle, `grant_valid`=000, MEM still busy until `mem_done`.
- Mixed issue: entries 0, 1, 2 request ALU0, ALU1, MEM in the same cycle. All three grant in one edge: `grant_valid`=111 and `grant_idx`={2,1,0}.

Source files
------------

// File: rtl/issue_sched_if.sv
// Issue-scheduler port bundle: reservation-station requests in, per-FU grants and FU
// availability out.
interface issue_sched_if #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDXW    = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_fu;
    logic                 mem_done;
    logic                 flush;
    logic [2:0]           grant_valid;
    logic [3*IDXW-1:0]    grant_idx;
    logic [2:0]           fu_free;

    modport master (
        output req_valid, req_fu, mem_done, flush,
        input  grant_valid, grant_idx, fu_free
    );

    modport slave (
        input  req_valid, req_fu, mem_done, flush,
        output grant_valid, grant_idx, fu_free
    );
endinterface

// File: rtl/issue_sched.sv
// Per-FU issue scheduler (ALU0, ALU1, MEM) with registered grants and an FU occupancy table.
// Define ISSUE_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module issue_sched #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDXW    = 3,
    parameter int unsigned ALU_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    issue_sched_if.slave bus_io
);
    localparam int unsigned NumFu = 3;
    typedef logic [IDXW-1:0] idx_t;

    logic [NumFu-1:0]            grant_valid_q, grant_valid_d;
    logic [NumFu-1:0][IDXW-1:0]  grant_idx_q, grant_idx_d;
    logic [1:0][3:0]             alu_cnt_q, alu_cnt_d;
    logic                        mem_busy_q, mem_busy_d;
    logic [NumFu-1:0]            fu_free_q, fu_free_d;
    logic [NUM_REQ-1:0]          mask;
    logic [NumFu-1:0]            fu_ready;
    logic [NumFu-1:0][NUM_REQ-1:0] cand;
`ifndef ISSUE_FIXED_PRIO_EN
    logic [NumFu-1:0][IDXW-1:0]  rr_q, rr_d;
`endif

    // Entries granted last edge are still present in the station for one more cycle.
    always_comb begin
        mask = '0;
        for (int f = 0; f < NumFu; f++) begin
            if (grant_valid_q[f]) mask[grant_idx_q[f]] = 1'b1;
        end
    end

    // An ALU whose counter reaches zero on this edge may be re-granted on the same edge.
    assign fu_ready = {~mem_busy_q, (alu_cnt_q[1] < 4'd2), (alu_cnt_q[0] < 4'd2)};

    always_comb begin
        cand = '0;
        for (int f = 0; f < NumFu; f++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand[f][i] = bus_io.req_valid[i] && (bus_io.req_fu[2*i +: 2] == 2'(f)) &&
                             !mask[i] && fu_ready[f] && !bus_io.flush;
            end
        end
    end

    always_comb begin
        int unsigned j;
        j             = 0;
        grant_valid_d = '0;
        grant_idx_d   = grant_idx_q;
        for (int f = 0; f < NumFu; f++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ISSUE_FIXED_PRIO_EN
                j = k;
`else
                j = (int'(rr_q[f]) + k) % NUM_REQ;
`endif
                if (!grant_valid_d[f] && cand[f][j]) begin
                    grant_valid_d[f] = 1'b1;
                    grant_idx_d[f]   = idx_t'(j);
                end
            end
        end
    end

`ifndef ISSUE_FIXED_PRIO_EN
    always_comb begin
        rr_d = rr_q;
        for (int f = 0; f < NumFu; f++) begin
            if (grant_valid_d[f]) begin
                rr_d[f] = (grant_idx_d[f] == idx_t'(NUM_REQ - 1)) ? '0 : grant_idx_d[f] + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        for (int a = 0; a < 2; a++) begin
            if (bus_io.flush)          alu_cnt_d[a] = 4'd0;
            else if (grant_valid_d[a]) alu_cnt_d[a] = 4'(ALU_LAT);
            else if (alu_cnt_q[a] != 4'd0) alu_cnt_d[a] = alu_cnt_q[a] - 4'd1;
            else                       alu_cnt_d[a] = alu_cnt_q[a];
        end
        // Flush leaves MEM busy: the memory op is still in flight.
        if (grant_valid_d[2])     mem_busy_d = 1'b1;
        else if (bus_io.mem_done) mem_busy_d = 1'b0;
        else                      mem_busy_d = mem_busy_q;
        fu_free_d = {~mem_busy_d, (alu_cnt_d[1] == 4'd0), (alu_cnt_d[0] == 4'd0)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid_q <= '0;
            grant_idx_q   <= '0;
            alu_cnt_q     <= '0;
            mem_busy_q    <= 1'b0;
            fu_free_q     <= '1;
`ifndef ISSUE_FIXED_PRIO_EN
            rr_q          <= '0;
`endif
        end else begin
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            alu_cnt_q     <= alu_cnt_d;
            mem_busy_q    <= mem_busy_d;
            fu_free_q     <= fu_free_d;
`ifndef ISSUE_FIXED_PRIO_EN
            rr_q          <= rr_d;
`endif
        end
    end

    assign bus_io.grant_valid = grant_valid_q;
    assign bus_io.grant_idx   = grant_idx_q;
    assign bus_io.fu_free     = fu_free_q;
endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched (default round-robin build): one DUT with ALU_LAT=1 and one
// with ALU_LAT=4 for the flush scenario.
module tb_issue_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    issue_sched_if #(.NUM_REQ(8), .IDXW(3)) bus1 ();
    issue_sched_if #(.NUM_REQ(8), .IDXW(3)) bus4 ();

    issue_sched #(.NUM_REQ(8), .IDXW(3), .ALU_LAT(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus1.slave)
    );

    issue_sched #(.NUM_REQ(8), .IDXW(3), .ALU_LAT(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus4.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req1(input int idx, input logic [1:0] fu);
        bus1.req_valid[idx]     = 1'b1;
        bus1.req_fu[2*idx +: 2] = fu;
    endtask

    task automatic req4(input int idx, input logic [1:0] fu);
        bus4.req_valid[idx]     = 1'b1;
        bus4.req_fu[2*idx +: 2] = fu;
    endtask

    task automatic clear_all();
        bus1.req_valid = '0;
        bus1.req_fu    = '0;
        bus4.req_valid = '0;
        bus4.req_fu    = '0;
    endtask

    initial begin
        clear_all();
        bus1.mem_done = 1'b0;
        bus1.flush    = 1'b0;
        bus4.mem_done = 1'b0;
        bus4.flush    = 1'b0;

        // Reset and idle
        tick();
        tick();
        rst = 1'b0;
        check("rst_fu_free", 32'(bus1.fu_free), 32'h7);
        check("rst_gv", 32'(bus1.grant_valid), 32'h0);
        check("rst_gidx", 32'(bus1.grant_idx), 32'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_fu_free", 32'(bus1.fu_free), 32'h7);
            check("idle_gv", 32'(bus1.grant_valid), 32'h0);
        end

        // Entries 2 and 5 on ALU0, held: 2,5,2,5
        req1(2, 2'b00);
        req1(5, 2'b00);
        tick(); check("alt_gv0", 32'(bus1.grant_valid), 32'h1);
        check("alt_idx0", 32'(bus1.grant_idx[2:0]), 32'd2);
        check("alt_free0", 32'(bus1.fu_free), 32'h6);
        tick(); check("alt_gv1", 32'(bus1.grant_valid), 32'h1);
        check("alt_idx1", 32'(bus1.grant_idx[2:0]), 32'd5);
        tick(); check("alt_gv2", 32'(bus1.grant_valid), 32'h1);
        check("alt_idx2", 32'(bus1.grant_idx[2:0]), 32'd2);
        tick(); check("alt_gv3", 32'(bus1.grant_valid), 32'h1);
        check("alt_idx3", 32'(bus1.grant_idx[2:0]), 32'd5);
        clear_all();
        tick(); check("alt_done_gv", 32'(bus1.grant_valid), 32'h0);
        check("alt_done_free", 32'(bus1.fu_free), 32'h7);

        // Move ALU1 pointer to 6 via a grant to entry 5
        req1(5, 2'b01);
        tick(); check("rr_pre_gv", 32'(bus1.grant_valid), 32'h2);
        check("rr_pre_idx", 32'(bus1.grant_idx[5:3]), 32'd5);
        clear_all();
        tick(); check("rr_pre_idle", 32'(bus1.grant_valid), 32'h0);

        // Entries 0,6,7 on ALU1 from rr=6: 6,7,0,6
        req1(0, 2'b01);
        req1(6, 2'b01);
        req1(7, 2'b01);
        tick(); check("wrap_idx0", 32'(bus1.grant_idx[5:3]), 32'd6);
        check("wrap_gv0", 32'(bus1.grant_valid), 32'h2);
        tick(); check("wrap_idx1", 32'(bus1.grant_idx[5:3]), 32'd7);
        tick(); check("wrap_idx2", 32'(bus1.grant_idx[5:3]), 32'd0);
        tick(); check("wrap_idx3", 32'(bus1.grant_idx[5:3]), 32'd6);
        check("wrap_gv3", 32'(bus1.grant_valid), 32'h2);
        clear_all();
        tick(); check("wrap_done_gv", 32'(bus1.grant_valid), 32'h0);

        // MEM occupancy
        req1(1, 2'b10);
        req1(3, 2'b10);
        tick(); check("mem_gv", 32'(bus1.grant_valid), 32'h4);
        check("mem_idx", 32'(bus1.grant_idx[8:6]), 32'd1);
        check("mem_free", 32'(bus1.fu_free), 32'h3);
        bus1.req_valid[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("mem_hold_gv", 32'(bus1.grant_valid), 32'h0);
            check("mem_hold_free", 32'(bus1.fu_free), 32'h3);
        end
        bus1.mem_done = 1'b1;
        tick(); check("mem_done_free", 32'(bus1.fu_free), 32'h7);
        check("mem_done_gv", 32'(bus1.grant_valid), 32'h0);
        bus1.mem_done = 1'b0;
        tick(); check("mem_next_gv", 32'(bus1.grant_valid), 32'h4);
        check("mem_next_idx", 32'(bus1.grant_idx[8:6]), 32'd3);
        check("mem_next_free", 32'(bus1.fu_free), 32'h3);
        clear_all();
        bus1.mem_done = 1'b1;
        tick(); check("mem_release", 32'(bus1.fu_free), 32'h7);
        bus1.mem_done = 1'b0;

        // Flush on the ALU_LAT=4 instance with MEM busy
        req4(0, 2'b10);
        req4(1, 2'b00);
        tick(); check("fl_gv", 32'(bus4.grant_valid), 32'h5);
        check("fl_idx0", 32'(bus4.grant_idx[2:0]), 32'd1);
        check("fl_idx2", 32'(bus4.grant_idx[8:6]), 32'd0);
        check("fl_free0", 32'(bus4.fu_free), 32'h2);
        clear_all();
        tick(); check("fl_busy", 32'(bus4.fu_free), 32'h2);
        check("fl_busy_gv", 32'(bus4.grant_valid), 32'h0);
        bus4.flush = 1'b1;
        req4(5, 2'b01);
        tick(); check("fl_gv_clr", 32'(bus4.grant_valid), 32'h0);
        check("fl_free", 32'(bus4.fu_free), 32'h3);
        bus4.flush = 1'b0;
        clear_all();
        tick(); check("fl_mem_kept", 32'(bus4.fu_free), 32'h3);
        bus4.mem_done = 1'b1;
        tick(); check("fl_mem_done", 32'(bus4.fu_free), 32'h7);
        bus4.mem_done = 1'b0;

        // Mixed issue: all three FUs in one edge
        req1(0, 2'b00);
        req1(1, 2'b01);
        req1(2, 2'b10);
        tick(); check("mix_gv", 32'(bus1.grant_valid), 32'h7);
        check("mix_idx", 32'(bus1.grant_idx), 32'h088);
        check("mix_free", 32'(bus1.fu_free), 32'h0);
        clear_all();

        // FU id 11 is never granted
        req1(3, 2'b11);
        bus1.mem_done = 1'b1;
        tick(); check("none_gv", 32'(bus1.grant_valid), 32'h0);
        check("none_free", 32'(bus1.fu_free), 32'h7);
        bus1.mem_done = 1'b0;
        tick(); check("none_gv2", 32'(bus1.grant_valid), 32'h0);
        clear_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
